// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, microsteps and the strobe word shared by the control sequencer.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    typedef struct packed {
        logic halt;
        logic pc_inc;
        logic pc_write;
        logic pc_read;
        logic mar_write;
        logic ram_read;
        logic ram_write;
        logic ir_read;
        logic ir_write;
        logic a_read;
        logic a_write;
        logic alu_read;
        logic alu_sub;
        logic b_write;
        logic out_write;
        logic flags_write;
    } ctrl_word_t;

    localparam int NUM_STEPS = 5;

    localparam ctrl_word_t CTRL_FETCH0 = '{pc_read: 1'b1, mar_write: 1'b1, default: 1'b0};
    localparam ctrl_word_t CTRL_FETCH1 = '{ram_read: 1'b1, ir_write: 1'b1, pc_inc: 1'b1, default: 1'b0};
    localparam ctrl_word_t CTRL_HALT   = '{halt: 1'b1, default: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational microcode table (step, opcode, flags) -> strobe word.
// CTRL_COND_JUMP_EN enables JC/JZ; without it they decode as NOP.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  step_e      step_i,
    input  logic [3:0] opcode_i,
    input  logic       carry_i,
    input  logic       zero_i,
    output ctrl_word_t ctrl_o
);

    opcode_e op;
    assign op = opcode_e'(opcode_i);

`ifndef CTRL_COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = carry_i ^ zero_i;
`endif

    always_comb begin
        ctrl_o = '0;
        case (step_i)
            T0: ctrl_o = CTRL_FETCH0;
            T1: ctrl_o = CTRL_FETCH1;
            T2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_o.ir_read   = 1'b1;
                        ctrl_o.mar_write = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl_o.ir_read = 1'b1;
                        ctrl_o.a_write = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_o.ir_read  = 1'b1;
                        ctrl_o.pc_write = 1'b1;
                    end
`ifdef CTRL_COND_JUMP_EN
                    OP_JC: begin
                        ctrl_o.ir_read  = carry_i;
                        ctrl_o.pc_write = carry_i;
                    end
                    OP_JZ: begin
                        ctrl_o.ir_read  = zero_i;
                        ctrl_o.pc_write = zero_i;
                    end
`endif
                    OP_OUT: begin
                        ctrl_o.a_read    = 1'b1;
                        ctrl_o.out_write = 1'b1;
                    end
                    OP_HLT: ctrl_o.halt = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (op)
                    OP_LDA: begin
                        ctrl_o.ram_read = 1'b1;
                        ctrl_o.a_write  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_o.ram_read = 1'b1;
                        ctrl_o.b_write  = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_o.a_read    = 1'b1;
                        ctrl_o.ram_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    ctrl_o.alu_read    = 1'b1;
                    ctrl_o.a_write     = 1'b1;
                    ctrl_o.flags_write = 1'b1;
                    ctrl_o.alu_sub     = (op == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: five-step fetch/execute sequencer with halt latch and reset/halt gating.
// Build option: CTRL_COND_JUMP_EN (JC/JZ), handled inside ctrl_decode.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output ctrl_word_t ctrl,
    output logic [2:0] step,
    output logic       halted
);

    step_e      step_q, step_d;
    logic       halted_q, halted_d;
    ctrl_word_t dec;

    ctrl_decode u_decode (
        .step_i   (step_q),
        .opcode_i (opcode),
        .carry_i  (carry_flag),
        .zero_i   (zero_flag),
        .ctrl_o   (dec)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // The counter still advances on the HLT edge, so a halted machine rests in T3.
    always_comb begin
        step_d   = halted_q ? step_q : (step_q == T4 ? T0 : step_e'(step_q + 3'd1));
        halted_d = halted_q | dec.halt;
    end

    always_comb begin
        ctrl   = reset ? '0 : (halted_q ? CTRL_HALT : dec);
        step   = step_q;
        halted = halted_q;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random instruction streams checked against a scoreboard.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int          errors = 0;
    int          checks = 0;
    bit          m_halted = 1'b0;
    logic [19:0] sb[$];

`ifdef CTRL_COND_JUMP_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    control_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (ctrl),
        .step       (step),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int s, input logic [3:0] op, input logic c, input logic z);
        logic [15:0] r;
        r = 16'h0000;
        case (s)
            0: r = 16'h1800;
            1: r = 16'h4480;
            2: case (op)
                4'h1, 4'h2, 4'h3, 4'h4: r = 16'h0900;
                4'h5: r = 16'h0120;
                4'h6: r = 16'h2100;
                4'h7: r = (COND && c) ? 16'h2100 : 16'h0000;
                4'h8: r = (COND && z) ? 16'h2100 : 16'h0000;
                4'hE: r = 16'h0042;
                4'hF: r = 16'h8000;
                default: r = 16'h0000;
            endcase
            3: case (op)
                4'h1: r = 16'h0420;
                4'h2, 4'h3: r = 16'h0404;
                4'h4: r = 16'h0240;
                default: r = 16'h0000;
            endcase
            4: r = (op == 4'h2) ? 16'h0031 : (op == 4'h3) ? 16'h0039 : 16'h0000;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Expected steps are queued up front, then drained one per cycle at the falling edge.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input int n);
        logic [19:0] ent;
        for (int i = 0; i < n; i++) begin
            sb.push_back({m_halted, m_halted ? 3'd3 : 3'(i), m_halted ? 16'h8000 : model(i, op, c, z)});
            if (i == 2 && op == 4'hF) m_halted = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
            ent = sb.pop_front();
            chk("ctrl", ctrl, ent[15:0]);
            chk("step", {13'd0, step}, {13'd0, ent[18:16]});
            chk("halted", {15'd0, halted}, {15'd0, ent[19]});
            if (i == 1) begin
                opcode = op;
                carry_flag = c;
                zero_flag = z;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        chk("rst_ctrl", ctrl, 16'h0000);
        chk("rst_step", {13'd0, step}, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'h0000);
        repeat (cycles) begin
            @(negedge clock);
            chk("rst_hold_ctrl", ctrl, 16'h0000);
            chk("rst_hold_step", {13'd0, step}, 16'h0000);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_halted = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset)
            chk("bus_onehot0", {15'd0, $onehot0({ctrl[12], ctrl[10], ctrl[8], ctrl[6], ctrl[4]})}, 16'h0001);
    end

    initial begin
        logic [3:0] op;
        do_reset(3);
        run_instr(4'h2, 1'b0, 1'b0, 5);
        run_instr(4'h3, 1'b1, 1'b1, 5);
        run_instr(4'h7, 1'b0, 1'b1, 5);
        run_instr(4'h7, 1'b1, 1'b0, 5);
        run_instr(4'h8, 1'b1, 1'b0, 5);
        run_instr(4'h8, 1'b0, 1'b1, 5);
        run_instr(4'h1, 1'b0, 1'b0, 5);
        run_instr(4'h4, 1'b0, 1'b0, 5);
        run_instr(4'h5, 1'b0, 1'b0, 5);
        run_instr(4'h6, 1'b0, 1'b0, 5);
        run_instr(4'hE, 1'b0, 1'b0, 5);
        run_instr(4'h0, 1'b0, 1'b0, 5);
        run_instr(4'hA, 1'b1, 1'b1, 5);
        run_instr(4'h1, 1'b0, 1'b0, 4);
        do_reset(0);
        run_instr(4'h1, 1'b0, 1'b0, 5);
        run_instr(4'hF, 1'b0, 1'b0, 5);
        repeat (4) run_instr(4'h0, 1'b0, 1'b0, 5);
        do_reset(1);
        for (int k = 0; k < 1000; k++) begin
            op = 4'($urandom_range(0, 14));
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
